// File: rtl/num_accu_pkg.sv
// Shared constants and types for the element stream between the line
// serializer and the pipelined accumulator.
package num_accu_pkg;

  localparam int CACHE_W_DEF = 512;
  localparam int DATA_W_DEF  = 32;
  localparam int LANES       = CACHE_W_DEF / DATA_W_DEF;
  localparam int LANE_IDX_W  = (LANES > 1) ? $clog2(LANES) : 1;

  typedef logic [DATA_W_DEF-1:0]  elem_t;
  typedef logic [CACHE_W_DEF-1:0] line_t;

endpackage

// File: rtl/line_buf2.sv
// Two-entry line FIFO feeding the serializer.
// Head is always visible combinationally so lane selection needs no extra cycle.
module line_buf2 #(
  parameter int WIDTH = 512
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_sel;
  logic             rd_sel;
  logic [1:0]       count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_sel];

  // Storage is not reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_sel] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        wr_sel <= ~wr_sel;
      end
      if (do_pop) begin
        rd_sel <= ~rd_sel;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/num_split_tx.sv
// Serializes cache lines into one element per cycle with per-group last flag.
// Groups always start at lane 0 of a fresh line.
module num_split_tx
  import num_accu_pkg::*;
#(
  parameter int CACHE_WIDTH = CACHE_W_DEF,
  parameter int DATA_WIDTH  = DATA_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_WIDTH-1:0]  size_out,
  input  logic                   line_valid,
  input  logic [CACHE_WIDTH-1:0] line_data,
  output logic                   line_ready,
  input  logic                   hold,
  output logic                   inc,
  output logic [DATA_WIDTH-1:0]  array,
  output logic                   last,
  output logic                   busy
);

  localparam int NLANES = CACHE_WIDTH / DATA_WIDTH;
  localparam int IDX_W  = (NLANES > 1) ? $clog2(NLANES) : 1;
  localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(NLANES - 1);

  logic [CACHE_WIDTH-1:0] head;
  logic                   full;
  logic                   empty;
  logic                   push;
  logic                   pop;
  logic                   emit;
  logic                   is_last;

  logic [IDX_W-1:0]       ptr;
  logic [DATA_WIDTH-1:0]  cnt;
  logic [DATA_WIDTH-1:0]  grp_size;
  logic [DATA_WIDTH-1:0]  cur_size;
  logic [DATA_WIDTH-1:0]  cnt_next;
  logic [DATA_WIDTH-1:0]  lanes [NLANES];

  line_buf2 #(
    .WIDTH (CACHE_WIDTH)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (line_data),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  assign line_ready = !full;
  assign push       = line_valid && line_ready;
  assign emit       = !empty && !hold;
  assign busy       = !empty || inc;

  always_comb begin
    for (int k = 0; k < NLANES; k++) begin
      lanes[k] = head[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // A zero size is treated as one-element groups; size is only taken at group start.
  always_comb begin
    cur_size = grp_size;
    if (cnt == '0) begin
      cur_size = (size_out == '0) ? DATA_WIDTH'(1) : size_out;
    end
    cnt_next = cnt + DATA_WIDTH'(1);
    is_last  = (cnt_next == cur_size);
    pop      = emit && ((ptr == LAST_LANE) || is_last);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      cnt      <= '0;
      grp_size <= '0;
      inc      <= 1'b0;
      last     <= 1'b0;
      array    <= '0;
    end else if (emit) begin
      array    <= lanes[ptr];
      inc      <= 1'b1;
      last     <= is_last;
      grp_size <= cur_size;
      cnt      <= is_last ? '0 : cnt_next;
      ptr      <= pop ? '0 : ptr + IDX_W'(1);
    end else begin
      inc      <= 1'b0;
      last     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_num_split_tx.sv
// Self-checking bench for num_split_tx: randomized lines against a
// group/line-level reference model of the element stream.
module tb_num_split_tx;
  import num_accu_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  elem_t size_out = '0;
  logic  line_valid = 1'b0;
  line_t line_data = '0;
  logic  line_ready;
  logic  hold = 1'b0;
  logic  inc;
  elem_t array;
  logic  last;
  logic  busy;

  int tests_run = 0;
  int tests_failed = 0;
  longint cyc = 0;

  logic [DATA_W_DEF:0] obs_q[$];
  longint              obs_t[$];
  logic [DATA_W_DEF:0] exp_q[$];
  int                  rem = 0;

  num_split_tx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .size_out   (size_out),
    .line_valid (line_valid),
    .line_data  (line_data),
    .line_ready (line_ready),
    .hold       (hold),
    .inc        (inc),
    .array      (array),
    .last       (last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (inc) begin
      obs_q.push_back({last, array});
      obs_t.push_back(cyc);
    end
  end

  // Reference: each line yields lanes from 0 until the line ends or a group closes.
  function automatic void model_line(input line_t d, input elem_t sz);
    logic  lst;
    elem_t v;
    for (int k = 0; k < LANES; k++) begin
      if (rem == 0) rem = (sz == 0) ? 1 : int'(sz);
      v   = d[k*DATA_W_DEF +: DATA_W_DEF];
      lst = (rem == 1);
      exp_q.push_back({lst, v});
      rem--;
      if (lst) break;
    end
  endfunction

  function automatic line_t seq_line(input int base);
    line_t l;
    for (int k = 0; k < LANES; k++) l[k*DATA_W_DEF +: DATA_W_DEF] = elem_t'(base + k);
    return l;
  endfunction

  function automatic line_t rand_line();
    line_t l;
    for (int k = 0; k < LANES; k++) l[k*DATA_W_DEF +: DATA_W_DEF] = $urandom;
    return l;
  endfunction

  task automatic send_line(input line_t d);
    int t;
    @(negedge clk);
    line_valid = 1'b1;
    line_data  = d;
    t = 0;
    while (!line_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!line_ready) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL send_line_timeout line_ready=%0b required 1", line_ready);
    end else begin
      @(posedge clk);
      model_line(d, size_out);
    end
    #1 line_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t;
    @(negedge clk);
    t = 0;
    while (busy && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (busy) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL %s_idle_timeout busy=%0b required 0", name, busy);
    end
  endtask

  task automatic compare_and_clear(input string name);
    int n;
    tests_run++;
    if (obs_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("[TB] FAIL %s_count got %0d elements required %0d", name, obs_q.size(), exp_q.size());
    end
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      tests_run++;
      if (obs_q[i] !== exp_q[i]) begin
        tests_failed++;
        $display("[TB] FAIL %s_elem%0d got last=%0b val=%0h required last=%0b val=%0h",
                 name, i, obs_q[i][DATA_W_DEF], obs_q[i][DATA_W_DEF-1:0],
                 exp_q[i][DATA_W_DEF], exp_q[i][DATA_W_DEF-1:0]);
      end
    end
    obs_q.delete();
    obs_t.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({inc, last, array, busy, line_ready} !== {1'b0, 1'b0, elem_t'(0), 1'b0, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL reset_state got inc=%0b last=%0b array=%0h busy=%0b ready=%0b required 0 0 0 0 1",
               inc, last, array, busy, line_ready);
    end
    size_out = 16;
    send_line(rand_line());
    send_line(rand_line());
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({inc, last, array, busy} !== {1'b0, 1'b0, elem_t'(0), 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid got inc=%0b last=%0b array=%0h busy=%0b required 0 0 0 0",
               inc, last, array, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    obs_q.delete();
    obs_t.delete();
    exp_q.delete();
    rem = 0;
    repeat (40) @(negedge clk);
    tests_run++;
    if (obs_q.size() != 0 || line_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_stale got %0d elements ready=%0b required 0 elements ready=1",
               obs_q.size(), line_ready);
    end
  endtask

  task automatic test_full_line();
    size_out = 16;
    send_line(seq_line(1));
    @(negedge clk);
    tests_run++;
    if (inc !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL full_latency got inc=%0b one edge after accept required 0", inc);
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      tests_run++;
      if ({inc, last, array} !== {1'b1, (i == 15), elem_t'(i + 1)}) begin
        tests_failed++;
        $display("[TB] FAIL full_stream%0d got inc=%0b last=%0b array=%0d required 1 %0b %0d",
                 i, inc, last, array, (i == 15), i + 1);
      end
    end
    @(negedge clk);
    tests_run++;
    if (inc !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL full_end got inc=%0b required 0", inc);
    end
    wait_idle("full");
    compare_and_clear("full");
  endtask

  task automatic test_early_last();
    size_out = 5;
    send_line(seq_line(1));
    send_line(seq_line(101));
    wait_idle("early");
    compare_and_clear("early");
  endtask

  task automatic test_span();
    line_t l3;
    size_out = 40;
    l3 = rand_line();
    send_line(rand_line());
    send_line(rand_line());
    send_line(l3);
    wait_idle("span");
    tests_run++;
    if (obs_t.size() != 40 || obs_t[obs_t.size()-1] - obs_t[0] != 39) begin
      tests_failed++;
      $display("[TB] FAIL span_gapless got %0d strobes over %0d cycles required 40 over 40",
               obs_t.size(), (obs_t.size() > 0) ? obs_t[obs_t.size()-1] - obs_t[0] + 1 : 0);
    end
    tests_run++;
    if (obs_q.size() < 40 || obs_q[39] !== {1'b1, l3[7*DATA_W_DEF +: DATA_W_DEF]}) begin
      tests_failed++;
      $display("[TB] FAIL span_last got %0h required %0h",
               (obs_q.size() >= 40) ? obs_q[39] : '0, {1'b1, l3[7*DATA_W_DEF +: DATA_W_DEF]});
    end
    compare_and_clear("span");
  endtask

  task automatic test_hold();
    size_out = 16;
    fork
      begin
        send_line(seq_line(1));
        send_line(seq_line(101));
        send_line(rand_line());
      end
      begin
        int t;
        t = 0;
        while (obs_q.size() < 4 && t < 200) begin
          @(negedge clk);
          #1 t++;
        end
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          #1;
          tests_run++;
          if ({inc, array, line_ready} !== {1'b0, elem_t'(4), 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL hold_cycle%0d got inc=%0b array=%0d ready=%0b required 0 4 0",
                     i, inc, array, line_ready);
          end
        end
        hold = 1'b0;
      end
    join
    wait_idle("hold");
    compare_and_clear("hold");
  endtask

  task automatic test_size_zero();
    size_out = 0;
    send_line(rand_line());
    send_line(rand_line());
    wait_idle("zero");
    tests_run++;
    if (obs_q.size() != 2 || obs_q[0][DATA_W_DEF] !== 1'b1 || obs_q[1][DATA_W_DEF] !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL zero_groups got %0d elements required 2 each with last=1", obs_q.size());
    end
    compare_and_clear("zero");
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      int  n;
      logic done;
      if (rem == 0) size_out = $urandom_range(0, 40);
      n = $urandom_range(1, 3);
      done = 1'b0;
      fork
        begin
          for (int i = 0; i < n; i++) send_line(rand_line());
          done = 1'b1;
        end
        begin
          while (!done) begin
            @(negedge clk);
            hold = ($urandom_range(0, 3) == 0);
          end
          hold = 1'b0;
        end
      join
      wait_idle("random");
      compare_and_clear("random");
    end
  endtask

  initial begin
    test_reset();
    test_full_line();
    test_early_last();
    test_span();
    test_hold();
    test_size_zero();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
